buzzer_beep_scheduler: RTL and testbench

Shares the single board buzzer between two requesters: a debounced key (one short beep per press) and an alarm level (repeating two-tone pattern while asserted). It time-sequences tones and gaps, arbitrates with fixed alarm priority, and drives the buzzer pin via an internal square-wave tone generator. It sits between the key debouncer and the buzzer pin, replacing direct PWM drive from the key path.

---
 rtl/buzzer_pkg.sv | 27 ++
 rtl/buzzer_tone_gen.sv | 42 ++++
 rtl/buzzer_beep_scheduler.sv | 124 ++++++++++++
 tb/tb_buzzer_beep_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and default timing for the buzzer beep scheduler.
package buzzer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_BEEP,
        ALARM_HI,
        ALARM_LO,
        GAP
    } state_t;

    localparam logic [1:0] GRANT_NONE  = 2'b00;
    localparam logic [1:0] GRANT_KEY   = 2'b01;
    localparam logic [1:0] GRANT_ALARM = 2'b10;

    localparam int unsigned DEF_MS_CYCLES = 50000;
    localparam int unsigned DEF_HALF_HI   = 12500;
    localparam int unsigned DEF_HALF_LO   = 25000;
    localparam int unsigned DEF_BEEP_MS   = 100;
    localparam int unsigned DEF_GAP_MS    = 100;

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave generator: toggles tone every half_period cycles while enabled.
module buzzer_tone_gen #(
    parameter int unsigned HALF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [HALF_W-1:0] half_period,
    output logic              tone
);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (!en || restart) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == half_period - HALF_W'(1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + HALF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/buzzer_beep_scheduler.sv
// Shares one buzzer between a key beep and a repeating two-tone alarm,
// alarm having priority; sequences tone segments and the trailing gap.
module buzzer_beep_scheduler
    import buzzer_pkg::*;
#(
    parameter int unsigned MS_CYCLES = DEF_MS_CYCLES,
    parameter int unsigned HALF_HI   = DEF_HALF_HI,
    parameter int unsigned HALF_LO   = DEF_HALF_LO,
    parameter int unsigned BEEP_MS   = DEF_BEEP_MS,
    parameter int unsigned GAP_MS    = DEF_GAP_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_key,
    input  logic       req_alarm,
    input  logic       mute,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] grant
);

    localparam int unsigned MS_W     = cnt_width(MS_CYCLES);
    localparam int unsigned SEG_MAX  = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;
    localparam int unsigned SEG_W    = cnt_width(SEG_MAX);
    localparam int unsigned HALF_MAX = (HALF_HI > HALF_LO) ? HALF_HI : HALF_LO;
    localparam int unsigned HALF_W   = cnt_width(HALF_MAX + 1);

    state_t            state_q, state_d;
    logic              key_prev_q, key_prev_d;
    logic              key_pend_q, key_pend_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [SEG_W-1:0]  seg_ms_q, seg_ms_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q, busy_d;

    logic              key_edge, tick, seg_end, entry;
    logic [SEG_W-1:0]  seg_last;
    logic              tone_en;
    logic [HALF_W-1:0] half_sel;
    logic              tone;

    always_comb begin
        key_edge   = req_key & ~key_prev_q;
        key_prev_d = req_key;
        tick       = (ms_cnt_q == MS_W'(MS_CYCLES - 1));
        seg_last   = (state_q == GAP) ? SEG_W'(GAP_MS - 1) : SEG_W'(BEEP_MS - 1);
        seg_end    = tick && (seg_ms_q == seg_last);

        state_d = state_q;
        unique case (state_q)
            IDLE:     if (req_alarm) state_d = ALARM_HI;
                      else if (key_pend_q) state_d = KEY_BEEP;
            KEY_BEEP: if (req_alarm) state_d = ALARM_HI;
                      else if (seg_end) state_d = GAP;
            ALARM_HI: if (seg_end) state_d = ALARM_LO;
            ALARM_LO: if (seg_end) state_d = req_alarm ? ALARM_HI : GAP;
            GAP:      if (seg_end) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        entry = (state_d != state_q);

        // Timers restart on every state entry and sit at zero while idle.
        if (entry || state_q == IDLE) begin
            ms_cnt_d = '0;
            seg_ms_d = '0;
        end else if (tick) begin
            ms_cnt_d = '0;
            seg_ms_d = seg_ms_q + SEG_W'(1);
        end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
            seg_ms_d = seg_ms_q;
        end

        // A new edge in the same cycle as the KEY_BEEP entry keeps the request.
        key_pend_d = key_edge | (key_pend_q & ~(entry && state_d == KEY_BEEP));

        unique case (state_d)
            KEY_BEEP:           grant_d = GRANT_KEY;
            ALARM_HI, ALARM_LO: grant_d = GRANT_ALARM;
            default:            grant_d = GRANT_NONE;
        endcase
        busy_d = (state_d != IDLE);

        tone_en  = (state_d == KEY_BEEP) || (state_d == ALARM_HI) || (state_d == ALARM_LO);
        half_sel = (state_d == ALARM_LO) ? HALF_W'(HALF_LO) : HALF_W'(HALF_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            key_prev_q <= 1'b0;
            key_pend_q <= 1'b0;
            ms_cnt_q   <= '0;
            seg_ms_q   <= '0;
            grant_q    <= GRANT_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_prev_d;
            key_pend_q <= key_pend_d;
            ms_cnt_q   <= ms_cnt_d;
            seg_ms_q   <= seg_ms_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end

    buzzer_tone_gen #(
        .HALF_W(HALF_W)
    ) u_tone (
        .clk        (clk),
        .rst        (rst),
        .en         (tone_en),
        .restart    (entry),
        .half_period(half_sel),
        .tone       (tone)
    );

    assign buzzer = tone & ~mute;
    assign grant  = grant_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_buzzer_beep_scheduler.sv
// Directed bench for buzzer_beep_scheduler using short simulation timing.
module tb_buzzer_beep_scheduler;

    logic       clk = 1'b0;
    logic       rst, req_key, req_alarm, mute;
    logic       buzzer, busy;
    logic [1:0] grant;

    always #5 clk = ~clk;

    buzzer_beep_scheduler #(
        .MS_CYCLES(10),
        .HALF_HI  (2),
        .HALF_LO  (4),
        .BEEP_MS  (3),
        .GAP_MS   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_key  (req_key),
        .req_alarm(req_alarm),
        .mute     (mute),
        .buzzer   (buzzer),
        .busy     (busy),
        .grant    (grant)
    );

    typedef struct {
        logic       key;
        logic       alarm;
        logic       mute;
        int         n;
        logic [1:0] g;
        logic       b;
        int         rises;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_buz = 1'b0;

    function automatic void add(input logic k, input logic a, input logic m, input int n,
                                input logic [1:0] g, input logic b, input int r);
        vec_t v;
        v.key = k; v.alarm = a; v.mute = m; v.n = n; v.g = g; v.b = b; v.rises = r;
        vq.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Each row holds its inputs for n cycles; grant/busy must match every cycle,
    // buzzer must be 0 whenever nobody owns it, and rising edges are counted.
    task automatic apply(input string name);
        foreach (vq[i]) begin
            int         rises;
            int         errs;
            int         bad_cyc;
            logic [1:0] bad_g;
            logic       bad_b, bad_z;
            rises = 0; errs = 0; bad_cyc = 0;
            bad_g = '0; bad_b = 1'b0; bad_z = 1'b0;
            req_key = vq[i].key; req_alarm = vq[i].alarm; mute = vq[i].mute;
            for (int c = 0; c < vq[i].n; c++) begin
                step();
                if (buzzer && !prev_buz) rises++;
                prev_buz = buzzer;
                if (grant !== vq[i].g || busy !== vq[i].b || (vq[i].g == 2'b00 && buzzer !== 1'b0)) begin
                    if (errs == 0) begin
                        bad_cyc = c; bad_g = grant; bad_b = busy; bad_z = buzzer;
                    end
                    errs++;
                end
            end
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL %s row%0d: cycle %0d grant=%b busy=%b buzzer=%b, want grant=%b busy=%b (%0d bad cycles)",
                         name, i, bad_cyc, bad_g, bad_b, bad_z, vq[i].g, vq[i].b, errs);
            end
            if (vq[i].rises >= 0)
                check($sformatf("%s row%0d rises", name, i), rises, vq[i].rises);
        end
        vq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_key = 1'b0; req_alarm = 1'b0; mute = 1'b0;
        repeat (3) step();
        check("reset grant", int'(grant), 0);
        check("reset busy", int'(busy), 0);
        check("reset buzzer", int'(buzzer), 0);
        rst = 1'b0;

        add(0, 0, 0, 5, 2'b00, 0, 0);
        apply("idle");

        // Single key press: 30 cycles beep, 20 gap, then idle.
        add(1, 0, 0, 1, 2'b00, 0, 0);
        add(1, 0, 0, 30, 2'b01, 1, 7);
        add(0, 0, 0, 20, 2'b00, 1, 0);
        add(0, 0, 0, 5, 2'b00, 0, 0);
        apply("single_key");

        // Three bounce edges during the beep collapse into one extra beep.
        add(1, 0, 0, 1, 2'b00, 0, 0);
        add(1, 0, 0, 2, 2'b01, 1, -1);
        add(0, 0, 0, 2, 2'b01, 1, -1);
        add(1, 0, 0, 2, 2'b01, 1, -1);
        add(0, 0, 0, 2, 2'b01, 1, -1);
        add(1, 0, 0, 2, 2'b01, 1, -1);
        add(0, 0, 0, 2, 2'b01, 1, -1);
        add(1, 0, 0, 2, 2'b01, 1, -1);
        add(0, 0, 0, 16, 2'b01, 1, -1);
        add(0, 0, 0, 20, 2'b00, 1, 0);
        add(0, 0, 0, 1, 2'b00, 0, 0);
        add(0, 0, 0, 30, 2'b01, 1, 7);
        add(0, 0, 0, 20, 2'b00, 1, 0);
        add(0, 0, 0, 10, 2'b00, 0, 0);
        apply("bounce");

        // Alarm held 150 cycles: HI/LO/HI/LO/HI, then the in-progress LO, then gap.
        add(0, 1, 0, 30, 2'b10, 1, 7);
        add(0, 1, 0, 30, 2'b10, 1, 4);
        add(0, 1, 0, 30, 2'b10, 1, 7);
        add(0, 1, 0, 30, 2'b10, 1, 4);
        add(0, 1, 0, 30, 2'b10, 1, 7);
        add(0, 0, 0, 30, 2'b10, 1, 4);
        add(0, 0, 0, 20, 2'b00, 1, 0);
        add(0, 0, 0, 5, 2'b00, 0, 0);
        apply("alarm_hold");

        // Alarm preempts a key beep 10 cycles in; the beep is not replayed.
        add(1, 0, 0, 1, 2'b00, 0, 0);
        add(1, 0, 0, 10, 2'b01, 1, -1);
        add(1, 1, 0, 30, 2'b10, 1, 7);
        add(1, 0, 0, 30, 2'b10, 1, 4);
        add(0, 0, 0, 20, 2'b00, 1, 0);
        add(0, 0, 0, 10, 2'b00, 0, 0);
        apply("alarm_preempt");

        // Muted: key pressed during alarm plays after gap; buzzer silent throughout.
        add(0, 1, 1, 5, 2'b10, 1, 0);
        add(1, 1, 1, 25, 2'b10, 1, 0);
        add(1, 0, 1, 30, 2'b10, 1, 0);
        add(0, 0, 1, 20, 2'b00, 1, 0);
        add(0, 0, 1, 1, 2'b00, 0, 0);
        add(0, 0, 1, 30, 2'b01, 1, 0);
        add(0, 0, 1, 20, 2'b00, 1, 0);
        add(0, 0, 0, 5, 2'b00, 0, 0);
        apply("mute_queued_key");

        // Reset 15 cycles into ALARM_LO with a key pending.
        add(0, 1, 0, 10, 2'b10, 1, -1);
        add(1, 1, 0, 20, 2'b10, 1, -1);
        add(1, 1, 0, 15, 2'b10, 1, -1);
        apply("pre_reset");
        check("lo tone high before reset", int'(buzzer), 1);
        rst = 1'b1; req_key = 1'b0; req_alarm = 1'b0;
        step();
        check("mid reset grant", int'(grant), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset buzzer", int'(buzzer), 0);
        rst = 1'b0;
        prev_buz = buzzer;
        add(0, 0, 0, 40, 2'b00, 0, 0);
        apply("post_reset_no_replay");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
